// File: rtl/simd_mac_pipeline_if.sv
// Operand/result bus of the SIMD multiply-accumulate execute pipeline.
// master = Decode side driving operands and out_ready; slave = the pipeline.
interface simd_mac_pipeline_if #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int TAG_W  = 5
);
    localparam int W = LANES * LANE_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [TAG_W-1:0] tag_out;
    logic [W-1:0]     acc;

    modport master (
        output in_valid, op_a, op_b, mode, tag_in, flush, out_ready,
        input  in_ready, out_valid, result, tag_out, acc
    );

    modport slave (
        input  in_valid, op_a, op_b, mode, tag_in, flush, out_ready,
        output in_ready, out_valid, result, tag_out, acc
    );
endinterface

// File: rtl/simd_mac_pipeline.sv
// Multi-lane SIMD execute pipeline: per-lane ADD/MUL computed on entry, accumulation
// applied on entry to the last stage, valid/ready backpressure with collapsing bubbles.
module simd_mac_pipeline #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input logic                clk,
    input logic                rst,
    simd_mac_pipeline_if.slave bus
);
    localparam int W = LANES * LANE_W;
    localparam int L = STAGES - 1;

    typedef enum logic [1:0] {
        MODE_ADD   = 2'b00,
        MODE_MUL   = 2'b01,
        MODE_MAC   = 2'b10,
        MODE_MACLD = 2'b11
    } mode_t;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] r;
    logic [W-1:0]      pay [STAGES];
    mode_t             md  [STAGES];
    logic [TAG_W-1:0]  tg  [STAGES];
    logic [W-1:0]      acc_q;
    logic [W-1:0]      prod;
    logic [W-1:0]      fin;
    logic [W-1:0]      acc_nxt;

    // Handshake: a beat moves on a rising edge when valid && ready; stage k may load
    // whenever it is empty or stage k+1 is loading, so ready ripples back from out_ready.
    always_comb begin : ready_chain
        logic room;
        r    = '0;
        room = bus.out_ready;
        for (int k = L; k >= 0; k--) begin
            room = room || !v[k];
            r[k] = room;
        end
    end

    assign bus.in_ready = r[0] && !bus.flush;

    always_comb begin : lane_math
        prod    = '0;
        fin     = '0;
        acc_nxt = acc_q;
        for (int i = 0; i < LANES; i++) begin
            logic [LANE_W-1:0] a;
            logic [LANE_W-1:0] b;
            logic [LANE_W-1:0] s;
            logic [LANE_W-1:0] sum;
            a = bus.op_a[i*LANE_W +: LANE_W];
            b = bus.op_b[i*LANE_W +: LANE_W];
            prod[i*LANE_W +: LANE_W] = (mode_t'(bus.mode) == MODE_ADD) ? a + b : a * b;
            s   = pay[L-1][i*LANE_W +: LANE_W];
            sum = acc_q[i*LANE_W +: LANE_W] + s;
            fin[i*LANE_W +: LANE_W] = (md[L-1] == MODE_MAC) ? sum : s;
            if (md[L-1] == MODE_MAC) begin
                acc_nxt[i*LANE_W +: LANE_W] = sum;
            end else if (md[L-1] == MODE_MACLD) begin
                acc_nxt[i*LANE_W +: LANE_W] = s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v     <= '0;
            acc_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                pay[k] <= '0;
                md[k]  <= MODE_ADD;
                tg[k]  <= '0;
            end
        end else if (bus.flush) begin
            // Accumulator is deliberately left alone: the beat entering the last stage dies here.
            v <= '0;
        end else begin
            if (r[0]) begin
                v[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    pay[0] <= prod;
                    md[0]  <= mode_t'(bus.mode);
                    tg[0]  <= bus.tag_in;
                end
            end
            for (int k = 1; k < L; k++) begin
                if (r[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        pay[k] <= pay[k-1];
                        md[k]  <= md[k-1];
                        tg[k]  <= tg[k-1];
                    end
                end
            end
            // Only one beat can enter the last stage per cycle, so acc updates stay in program order.
            if (r[L]) begin
                v[L] <= v[L-1];
                if (v[L-1]) begin
                    pay[L] <= fin;
                    md[L]  <= md[L-1];
                    tg[L]  <= tg[L-1];
                    acc_q  <= acc_nxt;
                end
            end
        end
    end

    assign bus.out_valid = v[L];
    assign bus.result    = pay[L];
    assign bus.tag_out   = tg[L];
    assign bus.acc       = acc_q;
endmodule

// File: tb/tb_simd_mac_pipeline.sv
// Bench for simd_mac_pipeline: directed scenarios plus a randomized stream checked
// against a lane-arithmetic reference model and an expected-result queue.
module tb_simd_mac_pipeline;
    localparam int LANES = 8, LANE_W = 32, STAGES = 3, TAG_W = 5, W = 256;
    localparam int LANES2 = 4, LANE_W2 = 16, STAGES2 = 2, W2 = 64;
    localparam logic [1:0] M_ADD = 2'b00, M_MUL = 2'b01, M_MAC = 2'b10, M_MACLD = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simd_mac_pipeline_if #(.LANES(LANES), .LANE_W(LANE_W), .TAG_W(TAG_W)) bus ();
    simd_mac_pipeline_if #(.LANES(LANES2), .LANE_W(LANE_W2), .TAG_W(TAG_W)) bus2 ();

    simd_mac_pipeline #(.LANES(LANES), .LANE_W(LANE_W), .STAGES(STAGES), .TAG_W(TAG_W))
        u_dut (.clk(clk), .rst(rst), .bus(bus));
    simd_mac_pipeline #(.LANES(LANES2), .LANE_W(LANE_W2), .STAGES(STAGES2), .TAG_W(TAG_W))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int errors = 0;
    int checks = 0;
    logic [255:0]     model_acc;
    logic [255:0]     model_acc2;
    logic [W-1:0]     exp_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];
    logic [W-1:0]     exp_acc_q[$];

    // Reference: each lane is an independent modulo-2^lw integer with its own accumulator.
    function automatic void model_beat(input int lanes, input int lw, input logic [255:0] a,
                                       input logic [255:0] b, input logic [1:0] m,
                                       inout logic [255:0] accv, output logic [255:0] res);
        longint unsigned modv, x, y, p, cur, o, na;
        modv = 64'd1 << lw;
        res  = '0;
        for (int i = 0; i < lanes; i++) begin
            x   = 64'((a >> (i * lw)) % 256'(modv));
            y   = 64'((b >> (i * lw)) % 256'(modv));
            cur = 64'((accv >> (i * lw)) % 256'(modv));
            p   = (m == M_ADD) ? (x + y) % modv : (x * y) % modv;
            case (m)
                M_MAC:   begin o = (cur + p) % modv; na = o; end
                M_MACLD: begin o = p; na = p; end
                default: begin o = p; na = cur; end
            endcase
            res  = res | (256'(o) << (i * lw));
            accv = (accv & ~(256'(modv - 1) << (i * lw))) | (256'(na) << (i * lw));
        end
    endfunction

    function automatic logic [W-1:0] fill(input logic [31:0] val);
        logic [W-1:0] x;
        for (int i = 0; i < LANES; i++) x[i*32 +: 32] = val;
        return x;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] x;
        for (int i = 0; i < LANES; i++) x[i*32 +: 32] = $urandom();
        return x;
    endfunction

    task automatic drive(input logic vld, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] m, input logic [TAG_W-1:0] t);
        bus.in_valid = vld;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.mode     = m;
        bus.tag_in   = t;
    endtask

    task automatic idle_all();
        drive(1'b0, '0, '0, M_ADD, '0);
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.op_a      = '0;
        bus2.op_b      = '0;
        bus2.mode      = M_ADD;
        bus2.tag_in    = '0;
        bus2.flush     = 1'b0;
        bus2.out_ready = 1'b1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        idle_all();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_acc  = '0;
        model_acc2 = '0;
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
        checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result: got %h exp 0", bus.result); end
        checks++; if (bus.tag_out !== '0) begin errors++; $display("FAIL reset_tag: got %h exp 0", bus.tag_out); end
        checks++; if (bus.acc !== '0) begin errors++; $display("FAIL reset_acc: got %h exp 0", bus.acc); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); end
        checks++; if (bus2.out_valid !== 1'b0 || bus2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_small: got valid=%b ready=%b exp 0/1", bus2.out_valid, bus2.in_ready); end
    endtask

    task automatic test_add_latency();
        logic [W-1:0] a, er;
        for (int i = 0; i < LANES; i++) a[i*32 +: 32] = 32'(i);
        model_beat(LANES, LANE_W, a, fill(32'd10), M_ADD, model_acc, er);
        @(negedge clk);
        drive(1'b1, a, fill(32'd10), M_ADD, 5'd3);
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b exp 1", bus.in_ready); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            drive(1'b0, '0, '0, M_ADD, '0);
            #1;
            if (c == 3) begin
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: out_valid got %b exp 1 at cycle 3", bus.out_valid); end
                checks++; if (bus.result !== er) begin errors++; $display("FAIL add_result: got %h exp %h", bus.result, er); end
                checks++; if (bus.tag_out !== 5'd3) begin errors++; $display("FAIL add_tag: got %0d exp 3", bus.tag_out); end
                checks++; if (bus.acc !== model_acc[W-1:0]) begin errors++; $display("FAIL add_acc: got %h exp %h", bus.acc, model_acc); end
            end else begin
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_latency: out_valid got %b exp 0 at cycle %0d", bus.out_valid, c); end
            end
        end
    endtask

    task automatic test_mac_chain();
        logic [W-1:0] av[3], bv[3], ea[3];
        logic [1:0]   mv[3];
        av[0] = fill(32'd2); bv[0] = fill(32'd3); mv[0] = M_MACLD;
        av[1] = fill(32'd4); bv[1] = fill(32'd5); mv[1] = M_MAC;
        av[2] = fill(32'd1); bv[2] = fill(32'd1); mv[2] = M_MAC;
        for (int k = 0; k < 3; k++) model_beat(LANES, LANE_W, av[k], bv[k], mv[k], model_acc, ea[k]);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c < 3) drive(1'b1, av[c], bv[c], mv[c], 5'(20 + c));
            else drive(1'b0, '0, '0, M_ADD, '0);
            #1;
            if (c < 3) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mac_in_ready: got %b exp 1 cycle %0d", bus.in_ready, c); end
            end else if (c < 6) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.result !== ea[c-3] || bus.tag_out !== 5'(17 + c)) begin
                    errors++; $display("FAIL mac_result: got v=%b %h tag %0d exp %h tag %0d", bus.out_valid, bus.result, bus.tag_out, ea[c-3], 17 + c);
                end
            end else begin
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mac_tail_valid: got %b exp 0", bus.out_valid); end
            end
        end
        checks++; if (bus.acc !== fill(32'd27)) begin errors++; $display("FAIL mac_acc: got %h exp all lanes 27", bus.acc); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] av[5], bv[5], ea, er;
        logic [1:0]   mv[5];
        int idx, got, cyc;
        for (int k = 0; k < 5; k++) begin
            av[k] = rand_vec(); bv[k] = rand_vec(); mv[k] = 2'($urandom_range(0, 1));
        end
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b1, av[idx], bv[idx], mv[idx], 5'(10 + idx));
            bus.out_ready = 1'b0;
            #1;
            checks++; if (bus.in_ready !== (c < 3)) begin errors++; $display("FAIL bp_fill_ready: got %b exp %b cycle %0d", bus.in_ready, c < 3, c); end
            if (bus.in_valid && bus.in_ready) begin
                model_beat(LANES, LANE_W, av[idx], bv[idx], mv[idx], model_acc, er);
                exp_q.push_back(er); exp_tag_q.push_back(5'(10 + idx)); exp_acc_q.push_back(model_acc[W-1:0]);
                idx++;
            end
        end
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (idx < 5) drive(1'b1, av[idx], bv[idx], mv[idx], 5'(10 + idx));
            else drive(1'b0, '0, '0, M_ADD, '0);
            bus.out_ready = 1'b1;
            #1;
            if (cyc == 1) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_ready: got %b exp 1", bus.in_ready); end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: unexpected beat tag %0d", bus.tag_out);
                end else begin
                    ea = exp_q.pop_front();
                    if (bus.result !== ea || bus.tag_out !== exp_tag_q.pop_front() || bus.acc !== exp_acc_q.pop_front()) begin
                        errors++; $display("FAIL bp_order: got %h tag %0d exp %h", bus.result, bus.tag_out, ea);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                model_beat(LANES, LANE_W, av[idx], bv[idx], mv[idx], model_acc, er);
                exp_q.push_back(er); exp_tag_q.push_back(5'(10 + idx)); exp_acc_q.push_back(model_acc[W-1:0]);
                idx++;
            end
        end
        checks++; if (got != 5 || idx != 5) begin errors++; $display("FAIL bp_count: got %0d out %0d in exp 5/5", got, idx); end
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: out_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] av[3], bv[3], ea;
        logic [1:0]   mv[3];
        av[0] = fill(32'hFFFF_FFFF); bv[0] = fill(32'd2); mv[0] = M_MUL;
        av[1] = fill(32'hFFFF_FFFF); bv[1] = fill(32'd1); mv[1] = M_MACLD;
        av[2] = fill(32'd1);         bv[2] = fill(32'd1); mv[2] = M_MAC;
        for (int k = 0; k < 3; k++) model_beat(LANES, LANE_W, av[k], bv[k], mv[k], model_acc, ea);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 3) drive(1'b1, av[c], bv[c], mv[c], 5'd7);
            else drive(1'b0, '0, '0, M_ADD, '0);
            bus.out_ready = 1'b1;
            #1;
            if (c == 3) begin
                checks++; if (bus.result !== fill(32'hFFFF_FFFE)) begin errors++; $display("FAIL wrap_mul: got %h exp lanes fffffffe", bus.result); end
            end else if (c == 4) begin
                checks++; if (bus.acc !== fill(32'hFFFF_FFFF)) begin errors++; $display("FAIL wrap_macld_acc: got %h exp lanes ffffffff", bus.acc); end
            end else if (c == 5) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.result !== '0) begin errors++; $display("FAIL wrap_mac_result: got v=%b %h exp 0", bus.out_valid, bus.result); end
                checks++; if (bus.acc !== '0) begin errors++; $display("FAIL wrap_mac_acc: got %h exp 0", bus.acc); end
            end
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] av[4], bv[4], er;
        logic [1:0]   mv[4];
        av[0] = fill(32'd3); bv[0] = fill(32'd5); mv[0] = M_MACLD;
        av[1] = fill(32'd2); bv[1] = fill(32'd2); mv[1] = M_MAC;
        av[2] = fill(32'd1); bv[2] = fill(32'd7); mv[2] = M_MAC;
        av[3] = fill(32'd9); bv[3] = fill(32'd9); mv[3] = M_MAC;
        // Only the first beat reaches the last stage before the flush.
        model_beat(LANES, LANE_W, av[0], bv[0], mv[0], model_acc, er);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c < 4) drive(1'b1, av[c], bv[c], mv[c], 5'(c));
            else drive(1'b0, '0, '0, M_ADD, '0);
            bus.flush     = (c == 3);
            bus.out_ready = (c >= 4);
            #1;
            if (c < 3) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_fill_ready: got %b exp 1", bus.in_ready); end
            end else if (c == 3) begin
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b exp 0", bus.in_ready); end
                checks++; if (bus.acc !== model_acc[W-1:0]) begin errors++; $display("FAIL flush_pre_acc: got %h exp %h", bus.acc, model_acc); end
            end else begin
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b exp 0 cycle %0d", bus.out_valid, c); end
            end
        end
        checks++; if (bus.acc !== model_acc[W-1:0] || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_acc: got %h ready %b exp %h ready 1", bus.acc, bus.in_ready, model_acc);
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] av[3], bv[3], er;
        logic [1:0]   mv[3];
        av[0] = fill(32'd7); bv[0] = fill(32'd1); mv[0] = M_MACLD;
        av[1] = fill(32'd1); bv[1] = fill(32'd1); mv[1] = M_MAC;
        av[2] = fill(32'd2); bv[2] = fill(32'd2); mv[2] = M_MAC;
        model_beat(LANES, LANE_W, av[0], bv[0], mv[0], model_acc, er);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, av[c], bv[c], mv[c], 5'(c));
            bus.out_ready = 1'b0;
        end
        @(negedge clk);
        drive(1'b1, fill(32'd5), fill(32'd5), M_MAC, 5'd9);
        rst = 1'b1;
        #1;
        checks++; if (bus.acc !== model_acc[W-1:0] || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got acc %h v %b exp %h v 1", bus.acc, bus.out_valid, model_acc);
        end
        @(negedge clk);
        rst = 1'b0;
        model_acc  = '0;
        model_acc2 = '0;
        drive(1'b0, '0, '0, M_ADD, '0);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b exp 0", bus.out_valid); end
        checks++; if (bus.acc !== '0) begin errors++; $display("FAIL rstmid_acc: got %h exp 0", bus.acc); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b exp 1", bus.in_ready); end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_small_config();
        logic [255:0] a, b, er, macc;
        logic [W2-1:0] ea[4], eacc[4];
        logic [1:0]   mv[4];
        logic [W2-1:0] av[4], bv[4];
        for (int i = 0; i < LANES2; i++) av[0][i*16 +: 16] = 16'(i);
        bv[0] = {4{16'd10}}; mv[0] = M_ADD;
        for (int k = 1; k < 4; k++) begin
            av[k] = {$urandom(), $urandom()}; bv[k] = {$urandom(), $urandom()};
        end
        mv[1] = M_MUL; mv[2] = M_MACLD; mv[3] = M_MAC;
        macc = model_acc2;
        for (int k = 0; k < 4; k++) begin
            a = 256'(av[k]); b = 256'(bv[k]);
            model_beat(LANES2, LANE_W2, a, b, mv[k], macc, er);
            ea[k] = er[W2-1:0]; eacc[k] = macc[W2-1:0];
        end
        model_acc2 = macc;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            bus2.in_valid  = (c == 0) || (c >= 2 && c <= 4);
            bus2.op_a      = (c == 0) ? av[0] : (c >= 2 && c <= 4) ? av[c-1] : '0;
            bus2.op_b      = (c == 0) ? bv[0] : (c >= 2 && c <= 4) ? bv[c-1] : '0;
            bus2.mode      = (c == 0) ? mv[0] : (c >= 2 && c <= 4) ? mv[c-1] : M_ADD;
            bus2.tag_in    = (c == 0) ? 5'd3 : 5'(c);
            bus2.out_ready = 1'b1;
            #1;
            if (c == 1) begin
                checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL small_early: out_valid got %b exp 0", bus2.out_valid); end
            end else if (c == 2) begin
                checks++; if (bus2.out_valid !== 1'b1 || bus2.tag_out !== 5'd3) begin errors++; $display("FAIL small_latency: got v=%b tag %0d exp 1/3", bus2.out_valid, bus2.tag_out); end
                checks++; if (bus2.result !== {16'd13, 16'd12, 16'd11, 16'd10} || bus2.result !== ea[0]) begin
                    errors++; $display("FAIL small_pack: got %h exp 000d000c000b000a", bus2.result);
                end
                checks++; if (bus2.acc !== '0) begin errors++; $display("FAIL small_acc0: got %h exp 0", bus2.acc); end
            end else if (c >= 4) begin
                checks++; if (bus2.out_valid !== 1'b1 || bus2.result !== ea[c-3] || bus2.acc !== eacc[c-3]) begin
                    errors++; $display("FAIL small_beat%0d: got v=%b %h acc %h exp %h acc %h", c - 3, bus2.out_valid, bus2.result, bus2.acc, ea[c-3], eacc[c-3]);
                end
            end
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
    endtask

    task automatic test_random_stream();
        localparam int N = 40;
        logic [W-1:0] a, b, er, ea;
        logic [1:0] m;
        logic [TAG_W-1:0] t;
        int sent, got, cyc;
        exp_q.delete(); exp_tag_q.delete(); exp_acc_q.delete();
        a = rand_vec(); b = rand_vec(); m = 2'($urandom_range(0, 3)); t = 5'($urandom_range(0, 31));
        sent = 0; got = 0; cyc = 0;
        while (got < N && cyc < 600) begin
            @(negedge clk);
            cyc++;
            drive((sent < N) && ($urandom_range(0, 9) < 8), a, b, m, t);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra: unexpected beat tag %0d", bus.tag_out);
                end else begin
                    ea = exp_q.pop_front();
                    if (bus.result !== ea) begin errors++; $display("FAIL rand_result: got %h exp %h", bus.result, ea); end
                    checks++; if (bus.tag_out !== exp_tag_q[0]) begin errors++; $display("FAIL rand_tag: got %0d exp %0d", bus.tag_out, exp_tag_q[0]); end
                    checks++; if (bus.acc !== exp_acc_q[0]) begin errors++; $display("FAIL rand_acc: got %h exp %h", bus.acc, exp_acc_q[0]); end
                    void'(exp_tag_q.pop_front()); void'(exp_acc_q.pop_front());
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                model_beat(LANES, LANE_W, a, b, m, model_acc, er);
                exp_q.push_back(er); exp_tag_q.push_back(t); exp_acc_q.push_back(model_acc[W-1:0]);
                sent++;
                a = rand_vec(); b = rand_vec(); m = 2'($urandom_range(0, 3)); t = 5'($urandom_range(0, 31));
            end
        end
        checks++; if (got != N) begin errors++; $display("FAIL rand_timeout: got %0d results exp %0d", got, N); end
        @(negedge clk);
        drive(1'b0, '0, '0, M_ADD, '0);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_add_latency();
        test_mac_chain();
        test_backpressure();
        test_wrap();
        test_flush();
        test_reset_midop();
        test_small_config();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
